// File: rtl/uart_rx_pkg.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx_pkg
// Description : Shared UART types, default frame size and bit-timing helper.
// Revision    : 1.0 - initial release
// =============================================================================
package uart_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Divider value is one less than the bit period in clock cycles.
    function automatic int unsigned clkdiv_calc(input int unsigned clk_hz,
                                                input int unsigned baud);
        return clk_hz / baud - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx_if
// Description : Serial line, bit-timing control and received-byte signals.
// Revision    : 1.0 - initial release
// =============================================================================
interface uart_rx_if #(
    parameter int DATA_BITS = 8,
    parameter int CLKDIV_W  = 16
);
    logic [CLKDIV_W-1:0]  clkdiv;
    logic                 rx_serial;
    logic [DATA_BITS-1:0] rx_dout;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_err;

    modport master (
        output clkdiv, rx_serial,
        input  rx_dout, rx_done, rx_busy, frame_err
    );

    modport slave (
        input  clkdiv, rx_serial,
        output rx_dout, rx_done, rx_busy, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser with a parameterised reset value.
// Revision    : 1.0 - initial release
// =============================================================================
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic srstn,
    input  wire logic i_d,
    output logic      o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// =============================================================================
// Module      : uart_rx
// Description : UART receiver, 1 start / DATA_BITS data LSB first / 1 stop.
// Revision    : 1.0 - initial release
// =============================================================================
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int CLKDIV_W  = 16
) (
    input  wire logic clk,
    input  wire logic srstn,
    uart_rx_if.slave  bus
);
    localparam int                c_idx_w    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(DATA_BITS - 1);
    localparam logic [CLKDIV_W-1:0] c_one     = CLKDIV_W'(1);

    uart_state_t          r_state;
    logic [CLKDIV_W-1:0]  r_cnt;
    logic [CLKDIV_W-1:0]  r_div;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_dout;
    logic                 r_armed;
    logic                 r_done;
    logic                 r_busy;
    logic                 r_ferr;

    logic w_line;
    logic w_mid;
    logic w_bit_end;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .srstn (srstn),
        .i_d   (bus.rx_serial),
        .o_q   (w_line)
    );

    assign w_mid     = (r_cnt == (r_div >> 1));
    assign w_bit_end = (r_cnt == r_div);

    always_ff @(posedge clk) begin
        if (!srstn) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_div     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_dout    <= '0;
            r_armed   <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ferr <= 1'b0;
            case (r_state)
                IDLE: begin
                    // A low line only counts as a start once it has been seen high,
                    // so a break after a framing error is not re-received.
                    if (w_line) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= START;
                        r_div   <= bus.clkdiv;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_mid) begin
                        r_cnt <= '0;
                        if (!w_line) begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= w_line;
                        if (r_bit_idx == c_last_idx) begin
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        if (w_line) begin
                            r_dout <= r_shift;
                            r_done <= 1'b1;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_armed <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_dout   = r_dout;
    assign bus.rx_done   = r_done;
    assign bus.rx_busy   = r_busy;
    assign bus.frame_err = r_ferr;
endmodule
`default_nettype wire
